// File: rtl/cpu_pkg.sv
// Shared constants and types for the instruction fetch front-end.
package cpu_pkg;

    // Encoding presented to decode whenever no instruction is available.
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    // Default first fetch address after reset.
    localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;

    // One buffered fetch result: the word address it came from and its contents.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// The head is read combinationally from the registered array.
// A flush empties the FIFO and overrides any push or pop in the same cycle.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

    // The fetch credit scheme must never push into a full FIFO.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(push_i && !flush_i && !pop_i && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: issues sequential word fetches to a synchronous
// memory, buffers returned words with their PCs, and hands them to decode over
// a valid/ready handshake. A redirect flushes everything and restarts fetch.
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int                DEPTH      = 4,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEF)
) (
    input  logic              clk,
    input  logic              RST,
    output logic [ADDR_W-1:0] IADDR,
    output logic              IEN,
    input  logic [DATA_W-1:0] INSTR_IN,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_ADDR,
    output logic              INSTR_VALID,
    input  logic              INSTR_READY,
    output logic [DATA_W-1:0] INSTR_OUT,
    output logic [ADDR_W-1:0] INSTR_PC
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]        fetch_pc_q;
    logic [ADDR_W-1:0]        fetch_pc_d;
    logic                     run_q;
    logic                     inflight_q;
    logic [ADDR_W-1:0]        inflight_pc_q;

    logic [ADDR_W+DATA_W-1:0] head;
    logic                     fifo_valid;
    logic [CNT_W-1:0]         fifo_count;
    logic                     pop;
    logic                     push;
    logic                     issue;
    logic [CNT_W:0]           occupancy;

    // A redirect freezes the head and kills the response arriving this cycle.
    assign pop  = fifo_valid & INSTR_READY & ~REDIRECT;
    assign push = inflight_q & ~REDIRECT;

    // Slots already promised: buffered entries plus the outstanding fetch, less what leaves now.
    assign occupancy = {1'b0, fifo_count}
                     + {{CNT_W{1'b0}}, inflight_q}
                     - {{CNT_W{1'b0}}, pop};
    assign issue = run_q & ~REDIRECT & (occupancy < (CNT_W + 1)'(DEPTH));

    // Next fetch address: redirect target wins, otherwise advance on each issued fetch.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (REDIRECT) begin
            fetch_pc_d = REDIRECT_ADDR;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
        end
    end

    // Fetch PC, run enable and the single outstanding-fetch tracker.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            fetch_pc_q    <= RESET_ADDR;
            run_q         <= 1'b0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            run_q         <= 1'b1;
            inflight_q    <= issue;
            inflight_pc_q <= fetch_pc_q;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (RST),
        .flush_i     (REDIRECT),
        .push_i      (push),
        .push_data_i ({inflight_pc_q, INSTR_IN}),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    assign IEN         = issue;
    assign IADDR       = fetch_pc_q;
    assign INSTR_VALID = fifo_valid;
    assign INSTR_OUT   = fifo_valid ? head[DATA_W-1:0] : DATA_W'(NOP_INSTR);
    assign INSTR_PC    = fifo_valid ? head[ADDR_W+DATA_W-1:DATA_W] : '0;

endmodule
